// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs opcode, register, function and immediate fields
// into a 32-bit word, range-checks the immediate and buffers results in a small FIFO.
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             Flush_i,
    input  logic             Valid_i,
    output logic             Ready_o,
    input  logic [6:0]       Opcode_i,
    input  logic [4:0]       Rd_i,
    input  logic [4:0]       Rs1_i,
    input  logic [4:0]       Rs2_i,
    input  logic [2:0]       Funct3_i,
    input  logic [6:0]       Funct7_i,
    input  logic [31:0]      Immediate_i,
    output logic             Valid_o,
    input  logic             Ready_i,
    output logic [31:0]      Instruction_o,
    output logic             ImmErr_o,
    output logic [CNT_W-1:0] ErrCount_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    localparam logic [4:0] OPG_R      = 5'b01100;
    localparam logic [4:0] OPG_LOAD   = 5'b00000;
    localparam logic [4:0] OPG_OPIMM  = 5'b00100;
    localparam logic [4:0] OPG_JALR   = 5'b11001;
    localparam logic [4:0] OPG_STORE  = 5'b01000;
    localparam logic [4:0] OPG_BRANCH = 5'b11000;
    localparam logic [4:0] OPG_LUI    = 5'b01101;
    localparam logic [4:0] OPG_JAL    = 5'b11011;

    // Returns {range_error, instruction_word}; the word is always built from the
    // truncated immediate bits even when the range check fails.
    function automatic logic [32:0] encode(
        input logic        [6:0]  op,
        input logic        [4:0]  rd,
        input logic        [4:0]  rs1,
        input logic        [4:0]  rs2,
        input logic        [2:0]  f3,
        input logic        [6:0]  f7,
        input logic signed [31:0] imm
    );
        logic [31:0] word;
        logic        err;
        word = {25'b0, op};
        err  = 1'b1;
        case (op[6:2])
            OPG_R: begin
                word = {f7, rs2, rs1, f3, rd, op};
                err  = 1'b0;
            end
            OPG_LOAD, OPG_OPIMM, OPG_JALR: begin
                word = {imm[11:0], rs1, f3, rd, op};
                err  = (imm < -32'sd2048) || (imm > 32'sd2047);
            end
            OPG_STORE: begin
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                err  = (imm < -32'sd2048) || (imm > 32'sd2047);
            end
            OPG_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                err  = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
            end
            OPG_LUI: begin
                word = {imm[31:12], rd, op};
                err  = (imm[11:0] != 12'd0);
            end
            OPG_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                err  = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
            end
            default: ;
        endcase
        return {err, word};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}}) ? val : val + CNT_W'(1);
    endfunction

    logic [31:0]      r_mem_word [DEPTH];
    logic             r_mem_err  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_err_cnt;

    logic [32:0]      w_enc;
    logic             w_enc_err;
    logic [31:0]      w_enc_word;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_enc      = encode(Opcode_i, Rd_i, Rs1_i, Rs2_i, Funct3_i, Funct7_i,
                               $signed(Immediate_i));
    assign w_enc_err  = w_enc[32];
    assign w_enc_word = w_enc[31:0];

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = Valid_i && !w_full && !Flush_i;
    assign w_pop   = !w_empty && Ready_i && !Flush_i;

    assign Ready_o       = !w_full;
    assign Valid_o       = !w_empty;
    assign Instruction_o = w_empty ? 32'd0 : r_mem_word[r_rd_ptr];
    assign ImmErr_o      = w_empty ? 1'b0  : r_mem_err[r_rd_ptr];
    assign ErrCount_o    = r_err_cnt;

    // Stage p0: buffer storage, written only on accept
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_word[r_wr_ptr] <= w_enc_word;
            r_mem_err[r_wr_ptr]  <= w_enc_err;
        end
    end

    // Stage p0: pointers, occupancy and error counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
        end else if (Flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_enc_err) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, range errors, backpressure,
// flush, counter saturation and asynchronous reset.
module tb_instr_encoder;

    logic        clk_i;
    logic        rst_ni;
    logic        Flush_i;
    logic        Valid_i;
    logic        Ready_o;
    logic [6:0]  Opcode_i;
    logic [4:0]  Rd_i;
    logic [4:0]  Rs1_i;
    logic [4:0]  Rs2_i;
    logic [2:0]  Funct3_i;
    logic [6:0]  Funct7_i;
    logic [31:0] Immediate_i;
    logic        Valid_o;
    logic        Ready_i;
    logic [31:0] Instruction_o;
    logic        ImmErr_o;
    logic [7:0]  ErrCount_o;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder #(.DEPTH(2), .CNT_W(8)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .Flush_i       (Flush_i),
        .Valid_i       (Valid_i),
        .Ready_o       (Ready_o),
        .Opcode_i      (Opcode_i),
        .Rd_i          (Rd_i),
        .Rs1_i         (Rs1_i),
        .Rs2_i         (Rs2_i),
        .Funct3_i      (Funct3_i),
        .Funct7_i      (Funct7_i),
        .Immediate_i   (Immediate_i),
        .Valid_o       (Valid_o),
        .Ready_i       (Ready_i),
        .Instruction_o (Instruction_o),
        .ImmErr_o      (ImmErr_o),
        .ErrCount_o    (ErrCount_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        Opcode_i    = op;
        Rd_i        = rd;
        Rs1_i       = rs1;
        Rs2_i       = rs2;
        Funct3_i    = f3;
        Funct7_i    = f7;
        Immediate_i = imm;
        Valid_i     = 1'b1;
    endtask

    // Push one word with Ready_i=1, check it at the head, then check it pops.
    task automatic single(input string tag, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm,
                          input logic [31:0] exp_word, input logic exp_err,
                          input logic [7:0] exp_cnt);
        @(negedge clk_i);
        drive(op, rd, rs1, rs2, f3, f7, imm);
        @(posedge clk_i);
        #1 Valid_i = 1'b0;
        check({tag, "_vld"},  32'(Valid_o),    32'd1);
        check({tag, "_word"}, Instruction_o,   exp_word);
        check({tag, "_err"},  32'(ImmErr_o),   32'(exp_err));
        check({tag, "_cnt"},  32'(ErrCount_o), 32'(exp_cnt));
        @(posedge clk_i);
        #1;
        check({tag, "_popped"}, 32'(Valid_o), 32'd0);
    endtask

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    initial begin
        rst_ni  = 1'b0;
        Flush_i = 1'b0;
        Ready_i = 1'b1;
        drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        Valid_i = 1'b0;
        #23;
        check("rst_vld",  32'(Valid_o),       32'd0);
        check("rst_word", Instruction_o,      32'd0);
        check("rst_err",  32'(ImmErr_o),      32'd0);
        check("rst_cnt",  32'(ErrCount_o),   32'd0);
        rst_ni = 1'b1;
        #1 check("rst_rdy", 32'(Ready_o), 32'd1);

        // Encodings and range checks
        single("addi",   OP_IMM,     5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00500093, 1'b0, 8'd0);
        single("sw",     7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020A423, 1'b0, 8'd0);
        single("beq",    7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, 8'd0);
        single("lui",    7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, 8'd0);
        single("lui_e",  7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, 1'b1, 8'd1);
        single("jal_odd",7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h002000EF, 1'b1, 8'd2);
        single("jal_big",7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h800000EF, 1'b1, 8'd3);
        single("jal",    7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0, 8'd3);
        single("add",    7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0, 8'd3);
        single("badop",  OP_BAD,     5'd3, 5'd1, 5'd2, 3'd7, 7'd5, 32'd0,        32'h0000007F, 1'b1, 8'd4);
        single("i_hi",   OP_IMM,     5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h80000093, 1'b1, 8'd5);
        single("i_lo",   OP_IMM,     5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0, 8'd5);
        single("b_max",  7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,     32'h7E000FE3, 1'b0, 8'd5);

        // Backpressure: fill, stall, drain in order, push+pop at occupancy 1
        Ready_i = 1'b0;
        @(negedge clk_i); drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(posedge clk_i); #1;
        check("bp_rdy1", 32'(Ready_o), 32'd1);
        @(negedge clk_i); drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        @(posedge clk_i); #1;
        check("bp_full", 32'(Ready_o), 32'd0);
        @(negedge clk_i); drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        check("bp_headA", Instruction_o, 32'h00100093);
        @(posedge clk_i); #1;
        check("bp_stall", 32'(Ready_o), 32'd0);
        @(negedge clk_i); Ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("bp_headB", Instruction_o, 32'h00200093);
        check("bp_rdy2",  32'(Ready_o),  32'd1);
        @(posedge clk_i); #1;
        Valid_i = 1'b0;
        check("bp_headC", Instruction_o, 32'h00300093);
        check("bp_occ1",  32'(Ready_o),  32'd1);
        check("bp_vldC",  32'(Valid_o),  32'd1);
        @(posedge clk_i); #1;
        check("bp_empty", 32'(Valid_o), 32'd0);

        // Flush with two entries, then with one entry and a dropped error accept
        Ready_i = 1'b0;
        @(negedge clk_i); drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk_i); drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        @(negedge clk_i); drive(OP_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        Flush_i = 1'b1;
        @(posedge clk_i); #1;
        Flush_i = 1'b0; Valid_i = 1'b0;
        check("fl2_vld",  32'(Valid_o),     32'd0);
        check("fl2_word", Instruction_o,    32'd0);
        check("fl2_cnt",  32'(ErrCount_o), 32'd5);
        @(negedge clk_i); drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk_i); drive(OP_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        Flush_i = 1'b1;
        @(posedge clk_i); #1;
        Flush_i = 1'b0; Valid_i = 1'b0;
        check("fl1_vld", 32'(Valid_o),     32'd0);
        check("fl1_cnt", 32'(ErrCount_o), 32'd5);
        check("fl1_rdy", 32'(Ready_o),     32'd1);

        // Error counter saturation at 255
        Ready_i = 1'b1;
        @(negedge clk_i); drive(OP_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (249) @(posedge clk_i);
        #1 check("sat_254", 32'(ErrCount_o), 32'd254);
        @(posedge clk_i);
        #1 check("sat_255", 32'(ErrCount_o), 32'd255);
        repeat (3) @(posedge clk_i);
        #1 Valid_i = 1'b0;
        check("sat_hold", 32'(ErrCount_o), 32'd255);
        @(posedge clk_i); #1;

        // Asynchronous reset mid-stream
        Ready_i = 1'b0;
        @(negedge clk_i); drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk_i); drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        @(negedge clk_i); Valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("arst_vld",  32'(Valid_o),     32'd0);
        check("arst_word", Instruction_o,    32'd0);
        check("arst_err",  32'(ImmErr_o),    32'd0);
        check("arst_cnt",  32'(ErrCount_o), 32'd0);
        @(negedge clk_i); rst_ni = 1'b1; Ready_i = 1'b1;
        #1 check("arst_rdy", 32'(Ready_o), 32'd1);
        single("post_rst", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate decoder: packs opcode, register fields, function fields and a 32-bit immediate into a 32-bit RV32I instruction word.
- Used by the self-test instruction generator and the boot-ROM patch path.
- Valid/ready input side, 2-entry registered output buffer, per-instruction immediate range check with a saturating error counter.

Parameters:
- DEPTH, 2, output buffer entries (power of two, at least 2)
- CNT_W, 8, width of the error counter

Ports:
- clk_i input 1: clock, rising edge
- rst_ni input 1: asynchronous active-low reset
- Flush_i input 1: synchronous buffer clear
- Valid_i input 1: input fields valid
- Ready_o output 1: block can accept
- Opcode_i input 7: opcode[6:0]
- Rd_i input 5: destination register
- Rs1_i input 5: source register 1
- Rs2_i input 5: source register 2
- Funct3_i input 3: funct3
- Funct7_i input 7: funct7
- Immediate_i input 32: signed immediate value (byte offset for B and J)
- Valid_o output 1: Instruction_o valid
- Ready_i input 1: downstream accepts
- Instruction_o output 32: encoded instruction word
- ImmErr_o output 1: head entry failed its range check
- ErrCount_o output CNT_W: count of accepted instructions with an error, saturating

Behaviour:
- Reset (async, rst_ni=0):
  - buffer empty; Valid_o=0, Ready_o=1 after deassert
  - Instruction_o=0, ImmErr_o=0, ErrCount_o=0
  - a reset mid-stream discards all buffered entries.
- Accept: Valid_i && Ready_o at a clock edge. Ready_o = !full; there is no same-cycle bypass when full.
- Latency: an accepted word appears on Instruction_o and Valid_o in the cycle after the accept edge.
- Pop: Valid_o && Ready_i. Push and pop in the same cycle are allowed when not full; occupancy stays the same.
- FIFO order is preserved. Read/write pointers wrap modulo DEPTH.
- Empty buffer: Valid_o=0, Instruction_o=0, ImmErr_o=0.
- Flush_i: synchronous; empties the buffer; any accept in that same cycle is dropped; ErrCount_o is unchanged.
- Format is selected by Opcode_i[6:2]:
  - R (01100): {f7, rs2, rs1, f3, rd, op}; immediate ignored, no error
  - I (00000, 00100, 11001): {imm[11:0], rs1, f3, rd, op}; error unless -2048 <= imm <= 2047
  - S (01000): {imm[11:5], rs2, rs1, f3, imm[4:0], op}; same range as I
  - B (11000): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; error unless -4096 <= imm <= 4094 and imm[0]=0
  - U (01101): {imm[31:12], rd, op}; error if imm[11:0] != 0
  - J (11011): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; error unless -2^20 <= imm <= 2^20-2 and imm[0]=0
  - any other value: {25'b0, op} with error set
- On error the word is still encoded from truncated immediate bits and ImmErr_o is set for that entry.
- ErrCount_o increments by 1 at each accept whose entry has an error; it saturates at 2^CNT_W-1.
- Bits not used by a format (e.g. f7 for I) are ignored.

Test Plan:
- addi: op=0010011, rd=1, rs1=0, f3=0, imm=5 -> next cycle Valid_o=1, Instruction_o=0x00500093, ImmErr_o=0.
- sw: op=0100011, rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423. beq: op=1100011, rs1=rs2=0, f3=0, imm=0xFFFFFFFC -> 0xFE000EE3.
- lui: op=0110111, rd=5, imm=0x12345000 -> 0x123452B7, ImmErr_o=0. Repeat with imm=0x12345001 -> ImmErr_o=1, ErrCount_o=1.
- jal: op=1101111, rd=1, imm=3 -> ImmErr_o=1; imm=0x100000 -> ImmErr_o=1; imm=0x800 -> 0x001000EF, no error. Preload ErrCount_o at 255 (CNT_W=8) -> one more error leaves it at 255.
- Backpressure: Ready_i=0, drive 3 back-to-back words -> Ready_o=0 after 2 accepts; then Ready_i=1 -> words pop in order and Ready_o returns to 1. Simultaneous push and pop at occupancy 1 keeps occupancy at 1.
- Flush_i with 2 entries buffered -> Valid_o=0 next cycle, ErrCount_o unchanged. Assert rst_ni=0 mid-stream -> outputs go to 0 immediately, without waiting for a clock edge.
